// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencer.
package pipe_ctrl_pkg;

   // Per-stage stall vector: bit set = hold that pipeline register.
   typedef logic [4:0] stall_vec_t;

   localparam int STALL_IDX_PC     = 0;
   localparam int STALL_IDX_IF_ID  = 1;
   localparam int STALL_IDX_ID_EX  = 2;
   localparam int STALL_IDX_EX_MEM = 3;
   localparam int STALL_IDX_MEM_WB = 4;

   // A request from stage k holds stage k and everything upstream of it.
   localparam stall_vec_t STALL_NONE = 5'b00000;
   localparam stall_vec_t STALL_IF   = 5'b00011;
   localparam stall_vec_t STALL_ID   = 5'b00111;
   localparam stall_vec_t STALL_EX   = 5'b01111;
   localparam stall_vec_t STALL_MEM  = 5'b11111;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      MC_BUSY = 2'd1,
      MC_WAIT = 2'd2
   } pipe_ctrl_state_t;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Request/response bundle between the pipeline stages and the sequencer.
interface pipe_ctrl_if;
   import pipe_ctrl_pkg::*;

   logic        if_stallreq_i;
   logic        id_stallreq_i;
   logic        ex_mc_start_i;
   logic        ex_mc_kind_i;
   logic        mem_stallreq_i;
   logic        excp_valid_i;
   logic [31:0] excp_vector_i;
   stall_vec_t  stall_o;
   logic        flush_o;
   logic [31:0] new_pc_o;
   logic        ex_mc_busy_o;
   logic        ex_mc_done_o;

   // Pipeline side: raises requests, consumes stall/flush controls.
   modport master (
      output if_stallreq_i, id_stallreq_i, ex_mc_start_i, ex_mc_kind_i,
             mem_stallreq_i, excp_valid_i, excp_vector_i,
      input  stall_o, flush_o, new_pc_o, ex_mc_busy_o, ex_mc_done_o
   );

   // Sequencer side.
   modport slave (
      input  if_stallreq_i, id_stallreq_i, ex_mc_start_i, ex_mc_kind_i,
             mem_stallreq_i, excp_valid_i, excp_vector_i,
      output stall_o, flush_o, new_pc_o, ex_mc_busy_o, ex_mc_done_o
   );

endinterface

// File: rtl/pipe_ctrl_mc_counter.sv
// Down-counter for multi-cycle EX occupancy: clear, load, saturating decrement.
module mc_counter #(
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr_i,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_val_i,
   input  logic             dec_i,
   output logic             zero_o
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Next count: clear beats load beats decrement; decrement stops at zero.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = {CNT_W{1'b0}};
      end else if (load_i) begin
         cnt_d = load_val_i;
      end else if (dec_i && (cnt_q != {CNT_W{1'b0}})) begin
         cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Count register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= {CNT_W{1'b0}};
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_o = (cnt_q == {CNT_W{1'b0}});

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: merges stage stall requests, runs the EX multi-cycle
// unit, and issues a registered flush/redirect on exceptions.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int MUL_CYCLES = 2,
   parameter int DIV_CYCLES = 32,
   parameter int CNT_W      = 6
) (
   input  logic          clk,
   input  logic          rst,
   pipe_ctrl_if.slave    bus
);

   // Remaining cycles after the start cycle for each op kind.
   localparam logic [CNT_W-1:0] MUL_LEN = CNT_W'(MUL_CYCLES - 1);
   localparam logic [CNT_W-1:0] DIV_LEN = CNT_W'(DIV_CYCLES - 1);

   pipe_ctrl_state_t state_q, state_d;
   logic             flush_q, flush_d;
   logic [31:0]      new_pc_q, new_pc_d;

   logic             cnt_clr_s;
   logic             cnt_load_s;
   logic [CNT_W-1:0] cnt_load_val_s;
   logic             cnt_dec_s;
   logic             cnt_zero_s;
   logic [CNT_W-1:0] mc_len_s;
   logic             busy_s;
   logic             done_s;
   stall_vec_t       stall_s;

   mc_counter #(.CNT_W(CNT_W)) u_mc_counter (
      .clk        (clk),
      .rst        (rst),
      .clr_i      (cnt_clr_s),
      .load_i     (cnt_load_s),
      .load_val_i (cnt_load_val_s),
      .dec_i      (cnt_dec_s),
      .zero_o     (cnt_zero_s)
   );

   // FSM next state, counter control, busy/done and flush/redirect next values.
   // The start cycle itself counts as one cycle of occupancy, so the counter
   // is loaded with one less than the remaining length.
   always_comb begin
      state_d        = state_q;
      flush_d        = bus.excp_valid_i;
      new_pc_d       = bus.excp_valid_i ? bus.excp_vector_i : new_pc_q;
      cnt_clr_s      = 1'b0;
      cnt_load_s     = 1'b0;
      cnt_load_val_s = {CNT_W{1'b0}};
      cnt_dec_s      = 1'b0;
      busy_s         = 1'b0;
      done_s         = 1'b0;
      mc_len_s       = bus.ex_mc_kind_i ? DIV_LEN : MUL_LEN;

      if (bus.excp_valid_i) begin
         // Abort: no done pulse, a start in this cycle is dropped.
         state_d   = IDLE;
         cnt_clr_s = 1'b1;
         busy_s    = (state_q != IDLE);
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.ex_mc_start_i) begin
                  if (mc_len_s == {CNT_W{1'b0}}) begin
                     if (bus.mem_stallreq_i) begin
                        busy_s  = 1'b1;
                        state_d = MC_WAIT;
                     end else begin
                        done_s  = 1'b1;
                        state_d = IDLE;
                     end
                  end else begin
                     busy_s         = 1'b1;
                     cnt_load_s     = 1'b1;
                     cnt_load_val_s = mc_len_s - {{(CNT_W-1){1'b0}}, 1'b1};
                     state_d        = MC_BUSY;
                  end
               end else begin
                  state_d = IDLE;
               end
            end
            MC_BUSY: begin
               if (cnt_zero_s) begin
                  if (bus.mem_stallreq_i) begin
                     busy_s  = 1'b1;
                     state_d = MC_WAIT;
                  end else begin
                     done_s  = 1'b1;
                     state_d = IDLE;
                  end
               end else begin
                  busy_s    = 1'b1;
                  cnt_dec_s = 1'b1;
                  state_d   = MC_BUSY;
               end
            end
            MC_WAIT: begin
               if (bus.mem_stallreq_i) begin
                  busy_s  = 1'b1;
                  state_d = MC_WAIT;
               end else begin
                  done_s  = 1'b1;
                  state_d = IDLE;
               end
            end
            default: begin
               state_d   = IDLE;
               cnt_clr_s = 1'b1;
            end
         endcase
      end
   end

   // Stall priority encoder; everything is held quiet while reset is low.
   always_comb begin
      stall_s = STALL_NONE;
      if (!rst) begin
         stall_s = STALL_NONE;
      end else if (flush_q) begin
         stall_s = STALL_NONE;
      end else if (bus.mem_stallreq_i) begin
         stall_s = STALL_MEM;
      end else if (busy_s) begin
         stall_s = STALL_EX;
      end else if (bus.id_stallreq_i) begin
         stall_s = STALL_ID;
      end else if (bus.if_stallreq_i) begin
         stall_s = STALL_IF;
      end else begin
         stall_s = STALL_NONE;
      end
   end

   // FSM state plus the registered flush/redirect outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         flush_q  <= 1'b0;
         new_pc_q <= 32'h0000_0000;
      end else begin
         state_q  <= state_d;
         flush_q  <= flush_d;
         new_pc_q <= new_pc_d;
      end
   end

   assign bus.stall_o      = stall_s;
   assign bus.flush_o      = flush_q;
   assign bus.new_pc_o     = new_pc_q;
   assign bus.ex_mc_busy_o = rst & busy_s;
   assign bus.ex_mc_done_o = rst & done_s;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scenario bench for pipe_ctrl: expected output words are queued as each
// cycle is driven and popped/compared at the following falling edge.
module tb_pipe_ctrl;
   import pipe_ctrl_pkg::*;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;
   logic [31:0] exp_pc;
   logic [39:0] exp_q[$];

   pipe_ctrl_if bus ();

   pipe_ctrl #(.MUL_CYCLES(2), .DIV_CYCLES(32), .CNT_W(6)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // {stall, flush, new_pc, busy, done}
   function automatic logic [39:0] obs();
      return {bus.stall_o, bus.flush_o, bus.new_pc_o, bus.ex_mc_busy_o, bus.ex_mc_done_o};
   endfunction

   function automatic logic [39:0] mk(input stall_vec_t s, input logic f, input logic [31:0] pc,
                                      input logic b, input logic d);
      return {s, f, pc, b, d};
   endfunction

   task automatic drive(input logic st, input logic kd, input logic ifs, input logic ids,
                        input logic mems, input logic ex, input logic [31:0] vec);
      bus.ex_mc_start_i  = st;
      bus.ex_mc_kind_i   = kd;
      bus.if_stallreq_i  = ifs;
      bus.id_stallreq_i  = ids;
      bus.mem_stallreq_i = mems;
      bus.excp_valid_i   = ex;
      bus.excp_vector_i  = vec;
   endtask

   task automatic test_reset();
      logic [39:0] e, g;
      rst = 1'b0;
      drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF);
      for (int c = 0; c < 3; c++) begin
         exp_q.push_back(mk(STALL_NONE, 1'b0, 32'h0, 1'b0, 1'b0));
         @(negedge clk);
         g = obs(); e = exp_q.pop_front(); n_checks++;
         if (g !== e) begin n_fail++; $display("FAIL reset_hold c%0d got %h exp %h", c, g, e); end
         @(posedge clk);
      end
      #1;
      rst = 1'b1;
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      exp_pc = 32'h0;
      exp_q.push_back(mk(STALL_IF, 1'b0, exp_pc, 1'b0, 1'b0));
      @(negedge clk);
      g = obs(); e = exp_q.pop_front(); n_checks++;
      if (g !== e) begin n_fail++; $display("FAIL reset_release got %h exp %h", g, e); end
      @(posedge clk); #1;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
   endtask

   task automatic test_divide();
      logic [39:0] e, g;
      for (int c = 1; c <= 34; c++) begin
         @(posedge clk); #1;
         drive(c == 1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
         if (c <= 31)      exp_q.push_back(mk(STALL_EX,   1'b0, exp_pc, 1'b1, 1'b0));
         else if (c == 32) exp_q.push_back(mk(STALL_NONE, 1'b0, exp_pc, 1'b0, 1'b1));
         else              exp_q.push_back(mk(STALL_NONE, 1'b0, exp_pc, 1'b0, 1'b0));
         @(negedge clk);
         g = obs(); e = exp_q.pop_front(); n_checks++;
         if (g !== e) begin n_fail++; $display("FAIL divide c%0d got %h exp %h", c, g, e); end
      end
   endtask

   task automatic test_multiply();
      logic [39:0] e, g;
      // Plain multiply with an ID request underneath: EX stall dominates.
      for (int c = 1; c <= 3; c++) begin
         @(posedge clk); #1;
         drive(c == 1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
         if (c == 1)      exp_q.push_back(mk(STALL_EX, 1'b0, exp_pc, 1'b1, 1'b0));
         else if (c == 2) exp_q.push_back(mk(STALL_ID, 1'b0, exp_pc, 1'b0, 1'b1));
         else             exp_q.push_back(mk(STALL_ID, 1'b0, exp_pc, 1'b0, 1'b0));
         @(negedge clk);
         g = obs(); e = exp_q.pop_front(); n_checks++;
         if (g !== e) begin n_fail++; $display("FAIL mul c%0d got %h exp %h", c, g, e); end
      end
   endtask

   task automatic test_mul_mem_wait();
      logic [39:0] e, g;
      for (int c = 1; c <= 7; c++) begin
         @(posedge clk); #1;
         drive(c == 1, 1'b0, 1'b0, 1'b0, c <= 5, 1'b0, 32'h0);
         if (c <= 5)      exp_q.push_back(mk(STALL_MEM,  1'b0, exp_pc, 1'b1, 1'b0));
         else if (c == 6) exp_q.push_back(mk(STALL_NONE, 1'b0, exp_pc, 1'b0, 1'b1));
         else             exp_q.push_back(mk(STALL_NONE, 1'b0, exp_pc, 1'b0, 1'b0));
         @(negedge clk);
         g = obs(); e = exp_q.pop_front(); n_checks++;
         if (g !== e) begin n_fail++; $display("FAIL mul_mem_wait c%0d got %h exp %h", c, g, e); end
      end
   endtask

   task automatic test_excp_mid_divide();
      logic [39:0] e, g;
      for (int c = 1; c <= 40; c++) begin
         @(posedge clk); #1;
         drive(c == 1, 1'b1, 1'b0, 1'b0, 1'b0, c == 10, (c == 10) ? 32'hBFC0_0380 : 32'h0);
         if (c <= 10) begin
            exp_q.push_back(mk(STALL_EX, 1'b0, exp_pc, 1'b1, 1'b0));
         end else if (c == 11) begin
            exp_pc = 32'hBFC0_0380;
            exp_q.push_back(mk(STALL_NONE, 1'b1, exp_pc, 1'b0, 1'b0));
         end else begin
            exp_q.push_back(mk(STALL_NONE, 1'b0, exp_pc, 1'b0, 1'b0));
         end
         @(negedge clk);
         g = obs(); e = exp_q.pop_front(); n_checks++;
         if (g !== e) begin n_fail++; $display("FAIL excp_mid_div c%0d got %h exp %h", c, g, e); end
      end
   endtask

   task automatic test_priority();
      logic [39:0] e, g;
      logic [2:0]  req[6];
      stall_vec_t  want[6];
      // {if, id, mem}
      req[0] = 3'b110; want[0] = STALL_ID;
      req[1] = 3'b111; want[1] = STALL_MEM;
      req[2] = 3'b100; want[2] = STALL_IF;
      req[3] = 3'b010; want[3] = STALL_ID;
      req[4] = 3'b001; want[4] = STALL_MEM;
      req[5] = 3'b000; want[5] = STALL_NONE;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         drive(1'b0, 1'b0, req[i][2], req[i][1], req[i][0], 1'b0, 32'h0);
         exp_q.push_back(mk(want[i], 1'b0, exp_pc, 1'b0, 1'b0));
         @(negedge clk);
         g = obs(); e = exp_q.pop_front(); n_checks++;
         if (g !== e) begin n_fail++; $display("FAIL priority i%0d got %h exp %h", i, g, e); end
      end
   endtask

   task automatic test_start_with_excp();
      logic [39:0] e, g;
      for (int c = 1; c <= 5; c++) begin
         @(posedge clk); #1;
         drive(c == 1, 1'b1, 1'b0, 1'b0, 1'b0, c == 1, (c == 1) ? 32'h8000_0180 : 32'h0);
         if (c == 2) begin
            exp_pc = 32'h8000_0180;
            exp_q.push_back(mk(STALL_NONE, 1'b1, exp_pc, 1'b0, 1'b0));
         end else begin
            exp_q.push_back(mk(STALL_NONE, 1'b0, exp_pc, 1'b0, 1'b0));
         end
         @(negedge clk);
         g = obs(); e = exp_q.pop_front(); n_checks++;
         if (g !== e) begin n_fail++; $display("FAIL start_excp c%0d got %h exp %h", c, g, e); end
      end
   endtask

   task automatic test_flush_over_mem();
      logic [39:0] e, g;
      for (int c = 1; c <= 3; c++) begin
         @(posedge clk); #1;
         drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, c == 1, (c == 1) ? 32'h1234_5678 : 32'h0);
         if (c == 2) begin
            exp_pc = 32'h1234_5678;
            exp_q.push_back(mk(STALL_NONE, 1'b1, exp_pc, 1'b0, 1'b0));
         end else begin
            exp_q.push_back(mk(STALL_MEM, 1'b0, exp_pc, 1'b0, 1'b0));
         end
         @(negedge clk);
         g = obs(); e = exp_q.pop_front(); n_checks++;
         if (g !== e) begin n_fail++; $display("FAIL flush_over_mem c%0d got %h exp %h", c, g, e); end
      end
   endtask

   task automatic test_back_to_back();
      logic [39:0] e, g;
      for (int c = 1; c <= 5; c++) begin
         @(posedge clk); #1;
         drive(c == 1 || c == 3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
         if (c == 1 || c == 3)      exp_q.push_back(mk(STALL_EX,   1'b0, exp_pc, 1'b1, 1'b0));
         else if (c == 2 || c == 4) exp_q.push_back(mk(STALL_NONE, 1'b0, exp_pc, 1'b0, 1'b1));
         else                       exp_q.push_back(mk(STALL_NONE, 1'b0, exp_pc, 1'b0, 1'b0));
         @(negedge clk);
         g = obs(); e = exp_q.pop_front(); n_checks++;
         if (g !== e) begin n_fail++; $display("FAIL back_to_back c%0d got %h exp %h", c, g, e); end
      end
   endtask

   task automatic test_reset_mid_op();
      logic [39:0] e, g;
      for (int c = 1; c <= 9; c++) begin
         @(posedge clk); #1;
         drive(c == 1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
         if (c == 6) rst = 1'b0;
         if (c == 7) rst = 1'b1;
         if (c >= 6) exp_pc = 32'h0;
         if (c <= 5) exp_q.push_back(mk(STALL_EX,   1'b0, exp_pc, 1'b1, 1'b0));
         else        exp_q.push_back(mk(STALL_NONE, 1'b0, exp_pc, 1'b0, 1'b0));
         @(negedge clk);
         g = obs(); e = exp_q.pop_front(); n_checks++;
         if (g !== e) begin n_fail++; $display("FAIL reset_mid_op c%0d got %h exp %h", c, g, e); end
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      exp_pc   = 32'h0;
      test_reset();
      test_divide();
      test_multiply();
      test_mul_mem_wait();
      test_excp_mid_divide();
      test_priority();
      test_start_with_excp();
      test_flush_over_mem();
      test_back_to_back();
      test_reset_mid_op();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
